reg_file_2w_pc: RTL and testbench
=================================

Name: reg_file_2w_pc

Overview:
- Parametrised successor to the 16 x 32 single-write register file.
- Adds a second write port for base-register writeback, a synchronous reset of all registers, an internal auto-incrementing PC held in the top register, and write-to-read bypass.
- Sits between the decode stage (three read ports A/B/D) and the writeback stage.
- Provides the fetch PC directly.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 16, number of architectural registers; index NUM_REGS-1 is the PC.
- ADDR_W, 4, register index width; must equal clog2(NUM_REGS).
- PC_INC, 4, added to PC on each enabled advance.
- PC_RD_OFS, 8, offset added when the PC index is read through PA/PB/PD.
- RESET_PC, 0, PC value after reset.
- BYPASS, 1, enables same-cycle write-to-read forwarding (1 = on, 0 = off).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- LE  in  1  write enable, port 0 (primary writeback)
- RW  in  ADDR_W  write index, port 0
- PW  in  DATA_W  write data, port 0
- LE2  in  1  write enable, port 1 (base writeback)
- RW2  in  ADDR_W  write index, port 1
- PW2  in  DATA_W  write data, port 1
- PC_LE  in  1  PC advance enable (deassert to stall fetch)
- RA, RB, RD  in  ADDR_W  read indices
- PA, PB, PD  out  DATA_W  read data, combinational
- PC_out  out  DATA_W  current PC, registered

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset, while reset=1 at a rising edge:
  - Registers 0..NUM_REGS-2 <= 0.
  - PC <= RESET_PC.
  - All writes and PC advance that cycle are ignored (reset wins).
  - After reset: PC_out=RESET_PC; PA/PB/PD=0 for GPR indices and RESET_PC+PC_RD_OFS for the PC index.
- GPR writes, indices 0..NUM_REGS-2:
  - At the edge, if LE, R[RW] <= PW.
  - At the edge, if LE2, R[RW2] <= PW2.
  - Both ports to the same index: port 0 wins; port 1 data is discarded.
- PC update, priority order at each edge:
  1. reset.
  2. LE && RW==PC index: PC <= PW (branch). Applies even when PC_LE=0.
  3. PC_LE: PC <= PC + PC_INC, modulo 2^DATA_W (wraps silently).
  4. Otherwise hold.
  - LE2 with RW2==PC index is ignored. It never changes PC.
- Reads, combinational, zero latency, independent per port:
  - PC index: PC + PC_RD_OFS, modulo 2^DATA_W, using the current registered PC. No bypass for the PC index.
  - GPR index with BYPASS=1: LE && RW==index returns PW; else LE2 && RW2==index returns PW2; else R[index].
  - GPR index with BYPASS=0: returns R[index]; new data visible the cycle after the write.
  - Bypass is suppressed while reset=1; reads return stored values.
- PC_out = PC register, updated only at clock edges.
- Latency:
  - Write to read: 0 cycles with bypass, 1 cycle without.
  - Branch to PC_out: 1 cycle.
- No X propagation: every read index maps to a defined value; decoder and mux carry full default branches.

Decomposition:
- Package reg_file_pkg holds:
  - PC_IDX function (NUM_REGS-1).
  - Default constants: DATA_W_DEF, NUM_REGS_DEF, PC_INC_DEF, PC_RD_OFS_DEF.
  - Write-port priority enum: WP_PORT0, WP_PORT1, WP_NONE.
- One sub-module: reg_file_rd_port, a parametrised read mux with bypass compare and PC-offset select, instantiated three times (A, B, D).
- Storage and PC update stay in the top module.

Test Plan:
1. Reset then release, PC_LE=1 for 3 cycles:
   - PC_out: 0 -> 4 -> 8 -> 12.
   - RA=15 reads 20 in the last cycle.
   - PA=0 for RA=3.
2. LE=1, RW=5, PW=0xDEADBEEF, with RA=5 the same cycle:
   - BYPASS=1: PA=0xDEADBEEF combinationally.
   - Next cycle, LE=0: still reads 0xDEADBEEF.
   - BYPASS=0: first read is 0, next cycle reads 0xDEADBEEF.
3. LE=1 RW=7 PW=0x11 and LE2=1 RW2=7 PW2=0x22 in the same cycle:
   - RB=7 reads 0x11 both same cycle and after.
   - A following cycle with LE2 only (PW2=0x22) -> reads 0x22.
4. Branch: PC=0x100, PC_LE=1, LE=1 RW=15 PW=0x2000 -> PC_out=0x2000 next cycle, not 0x104. With LE2=1 RW2=15 PW2=0x3000 in place of the port-0 write -> PC_out=0x104.
5. Stall and wrap:
   - PC_LE=0 for 2 cycles: PC_out holds 0x40.
   - PC=0xFFFFFFFC, PC_LE=1: PC_out=0x0. RD=15 then reads 0x8.
6. Reset mid-operation: registers loaded, reset=1 coinciding with LE=1 RW=2 PW=0x55 and PC_LE=1:
   - Next cycle: R2=0, all GPRs read 0, PC_out=RESET_PC.
   - PA with RA=2 shows 0 (no bypass) during the reset cycle.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the two-write-port register file with an embedded PC.
// Imported by the top module and the read-port mux.
package reg_file_pkg;

  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned NUM_REGS_DEF  = 16;
  localparam int unsigned PC_INC_DEF    = 4;
  localparam int unsigned PC_RD_OFS_DEF = 8;

  // Which write port (if any) updates a given register this cycle.
  typedef enum logic [1:0] {
    WP_PORT0,
    WP_PORT1,
    WP_NONE
  } wp_sel_e;

  // The PC always lives in the topmost register slot.
  function automatic int unsigned PC_IDX(input int unsigned num_regs);
    return num_regs - 1;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: stored-value mux, optional write-to-read bypass,
// and the offset PC view for the PC index.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned NUM_REGS  = NUM_REGS_DEF,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned PC_RD_OFS = PC_RD_OFS_DEF,
  parameter bit          BYPASS    = 1'b1
) (
  input  logic                            reset,
  input  logic [ADDR_W-1:0]               raddr,
  input  logic [NUM_REGS-2:0][DATA_W-1:0] gpr,
  input  logic [DATA_W-1:0]               pc,
  input  logic                            we0,
  input  logic [ADDR_W-1:0]               waddr0,
  input  logic [DATA_W-1:0]               wdata0,
  input  logic                            we1,
  input  logic [ADDR_W-1:0]               waddr1,
  input  logic [DATA_W-1:0]               wdata1,
  output logic [DATA_W-1:0]               rdata
);

  localparam logic [ADDR_W-1:0] PcAddr = ADDR_W'(PC_IDX(NUM_REGS));
  localparam logic [DATA_W-1:0] PcOfs  = DATA_W'(PC_RD_OFS);

  logic [DATA_W-1:0] stored;
  logic              is_pc;
  logic              hit0;
  logic              hit1;

  // Full decode with a zero default so indices without a backing register never yield X.
  always_comb begin
    stored = '0;
    for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
      if (raddr == ADDR_W'(i)) begin
        stored = gpr[i];
      end
    end
  end

  // Bypass is disabled during reset so reads show the values being cleared, not the dropped write.
  always_comb begin
    is_pc = (raddr == PcAddr);
    hit0  = BYPASS && !reset && we0 && (waddr0 == raddr);
    hit1  = BYPASS && !reset && we1 && (waddr1 == raddr);
  end

  always_comb begin
    rdata = stored;
    if (is_pc) begin
      rdata = pc + PcOfs;
    end else if (hit0) begin
      rdata = wdata0;
    end else if (hit1) begin
      rdata = wdata1;
    end
  end

endmodule

// File: rtl/reg_file_2w_pc.sv
// Register file with two write ports, synchronous clear, an auto-incrementing PC in the
// top slot, and three combinational read ports (A/B/D) with optional bypass.
module reg_file_2w_pc
  import reg_file_pkg::*;
#(
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter int unsigned       NUM_REGS  = NUM_REGS_DEF,
  parameter int unsigned       ADDR_W    = 4,
  parameter int unsigned       PC_INC    = PC_INC_DEF,
  parameter int unsigned       PC_RD_OFS = PC_RD_OFS_DEF,
  parameter logic [DATA_W-1:0] RESET_PC  = '0,
  parameter bit                BYPASS    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              LE,
  input  logic [ADDR_W-1:0] RW,
  input  logic [DATA_W-1:0] PW,
  input  logic              LE2,
  input  logic [ADDR_W-1:0] RW2,
  input  logic [DATA_W-1:0] PW2,
  input  logic              PC_LE,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RD,
  output logic [DATA_W-1:0] PA,
  output logic [DATA_W-1:0] PB,
  output logic [DATA_W-1:0] PD,
  output logic [DATA_W-1:0] PC_out
);

  localparam logic [ADDR_W-1:0] PcAddr = ADDR_W'(PC_IDX(NUM_REGS));
  localparam logic [DATA_W-1:0] PcInc  = DATA_W'(PC_INC);

  logic [NUM_REGS-2:0][DATA_W-1:0] gpr_d;
  logic [NUM_REGS-2:0][DATA_W-1:0] gpr_q;
  logic [DATA_W-1:0]               pc_d;
  logic [DATA_W-1:0]               pc_q;
  wp_sel_e                         wp_sel [NUM_REGS-1];
  logic                            branch;

  // Port 0 has priority when both ports target the same register.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
      wp_sel[i] = WP_NONE;
      if (LE && (RW == ADDR_W'(i))) begin
        wp_sel[i] = WP_PORT0;
      end else if (LE2 && (RW2 == ADDR_W'(i))) begin
        wp_sel[i] = WP_PORT1;
      end
    end
  end

  always_comb begin
    gpr_d = gpr_q;
    for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
      case (wp_sel[i])
        WP_PORT0: gpr_d[i] = PW;
        WP_PORT1: gpr_d[i] = PW2;
        default:  gpr_d[i] = gpr_q[i];
      endcase
    end
  end

  // Only port 0 may redirect the PC; a port-1 write to the PC index is dropped.
  always_comb begin
    branch = LE && (RW == PcAddr);
    pc_d   = pc_q;
    if (branch) begin
      pc_d = PW;
    end else if (PC_LE) begin
      pc_d = pc_q + PcInc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpr_q <= '0;
      pc_q  <= RESET_PC;
    end else begin
      gpr_q <= gpr_d;
      pc_q  <= pc_d;
    end
  end

  assign PC_out = pc_q;

  reg_file_rd_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .PC_RD_OFS(PC_RD_OFS),
    .BYPASS   (BYPASS)
  ) u_rd_a (
    .reset (reset),
    .raddr (RA),
    .gpr   (gpr_q),
    .pc    (pc_q),
    .we0   (LE),
    .waddr0(RW),
    .wdata0(PW),
    .we1   (LE2),
    .waddr1(RW2),
    .wdata1(PW2),
    .rdata (PA)
  );

  reg_file_rd_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .PC_RD_OFS(PC_RD_OFS),
    .BYPASS   (BYPASS)
  ) u_rd_b (
    .reset (reset),
    .raddr (RB),
    .gpr   (gpr_q),
    .pc    (pc_q),
    .we0   (LE),
    .waddr0(RW),
    .wdata0(PW),
    .we1   (LE2),
    .waddr1(RW2),
    .wdata1(PW2),
    .rdata (PB)
  );

  reg_file_rd_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .PC_RD_OFS(PC_RD_OFS),
    .BYPASS   (BYPASS)
  ) u_rd_d (
    .reset (reset),
    .raddr (RD),
    .gpr   (gpr_q),
    .pc    (pc_q),
    .we0   (LE),
    .waddr0(RW),
    .wdata0(PW),
    .we1   (LE2),
    .waddr1(RW2),
    .wdata1(PW2),
    .rdata (PD)
  );

endmodule

// File: tb/tb_reg_file_2w_pc.sv
// Bench for reg_file_2w_pc: a bypass and a non-bypass instance share stimulus and are
// compared every cycle against an array-based model, plus directed literal checks.
module tb_reg_file_2w_pc;

  logic        clk = 1'b0;
  logic        reset;
  logic        LE, LE2, PC_LE;
  logic [3:0]  RW, RW2, RA, RB, RD;
  logic [31:0] PW, PW2;
  logic [31:0] pa_b, pb_b, pd_b, pc_b;
  logic [31:0] pa_n, pb_n, pd_n, pc_n;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_reg [0:14];
  logic [31:0] m_pc;
  bit          m_valid = 1'b0;

  always #5 clk = ~clk;

  reg_file_2w_pc #(.BYPASS(1'b1)) u_dut_byp (
    .clk(clk), .reset(reset),
    .LE(LE), .RW(RW), .PW(PW),
    .LE2(LE2), .RW2(RW2), .PW2(PW2),
    .PC_LE(PC_LE),
    .RA(RA), .RB(RB), .RD(RD),
    .PA(pa_b), .PB(pb_b), .PD(pd_b),
    .PC_out(pc_b)
  );

  reg_file_2w_pc #(.BYPASS(1'b0)) u_dut_nobyp (
    .clk(clk), .reset(reset),
    .LE(LE), .RW(RW), .PW(PW),
    .LE2(LE2), .RW2(RW2), .PW2(PW2),
    .PC_LE(PC_LE),
    .RA(RA), .RB(RB), .RD(RD),
    .PA(pa_n), .PB(pb_n), .PD(pd_n),
    .PC_out(pc_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // What a read of idx must return right now, from the architectural rules.
  function automatic logic [31:0] exp_rd(input logic [3:0] idx, input bit byp);
    if (idx == 4'd15) return m_pc + 32'd8;
    if (byp && !reset && LE && RW == idx) return PW;
    if (byp && !reset && LE2 && RW2 == idx) return PW2;
    return m_reg[idx];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) m_reg[i] <= 32'd0;
      m_pc    <= 32'd0;
      m_valid <= 1'b1;
    end else begin
      // Later nonblocking assignment wins, giving port 0 priority.
      if (LE2 && RW2 != 4'd15) m_reg[RW2] <= PW2;
      if (LE && RW != 4'd15) m_reg[RW] <= PW;
      if (LE && RW == 4'd15) m_pc <= PW;
      else if (PC_LE) m_pc <= m_pc + 32'd4;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_pc_byp", pc_b, m_pc);
      chk("model_pc_nobyp", pc_n, m_pc);
      chk("model_pa_byp", pa_b, exp_rd(RA, 1'b1));
      chk("model_pb_byp", pb_b, exp_rd(RB, 1'b1));
      chk("model_pd_byp", pd_b, exp_rd(RD, 1'b1));
      chk("model_pa_nobyp", pa_n, exp_rd(RA, 1'b0));
      chk("model_pb_nobyp", pb_n, exp_rd(RB, 1'b0));
      chk("model_pd_nobyp", pd_n, exp_rd(RD, 1'b0));
    end
  end

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; LE = 1'b0; LE2 = 1'b0; PC_LE = 1'b1;
    RW = '0; RW2 = '0; PW = '0; PW2 = '0;
    RA = 4'd15; RB = 4'd3; RD = 4'd0;

    // Reset, then free-running PC
    next_edge();
    next_edge();
    reset = 1'b0;
    #2;
    chk("reset_pc", pc_b, 32'h0);
    chk("reset_pa_pc_view", pa_b, 32'h8);
    chk("reset_pb_gpr", pb_b, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      next_edge();
      #2;
      chk("pc_advance", pc_b, 32'(k * 4));
    end
    chk("pc_read_ofs", pa_b, 32'd20);
    chk("gpr3_zero", pb_b, 32'h0);
    PC_LE = 1'b0;

    // Bypass vs. registered read
    LE = 1'b1; RW = 4'd5; PW = 32'hDEADBEEF; RA = 4'd5;
    #2;
    chk("bypass_same_cycle", pa_b, 32'hDEADBEEF);
    chk("nobypass_same_cycle", pa_n, 32'h0);
    next_edge();
    LE = 1'b0;
    #2;
    chk("bypass_next_cycle", pa_b, 32'hDEADBEEF);
    chk("nobypass_next_cycle", pa_n, 32'hDEADBEEF);

    // Same-index collision: port 0 wins
    LE = 1'b1; RW = 4'd7; PW = 32'h11; LE2 = 1'b1; RW2 = 4'd7; PW2 = 32'h22; RB = 4'd7;
    #2;
    chk("collide_bypass", pb_b, 32'h11);
    chk("collide_nobypass_old", pb_n, 32'h0);
    next_edge();
    LE = 1'b0; LE2 = 1'b0;
    #2;
    chk("collide_stored_byp", pb_b, 32'h11);
    chk("collide_stored_nobyp", pb_n, 32'h11);
    LE2 = 1'b1; RW2 = 4'd7; PW2 = 32'h22;
    #2;
    chk("port1_bypass", pb_b, 32'h22);
    next_edge();
    LE2 = 1'b0;
    #2;
    chk("port1_stored", pb_n, 32'h22);

    // Branch beats increment; port-1 write to PC is ignored
    LE = 1'b1; RW = 4'd15; PW = 32'h100;
    next_edge();
    #2;
    chk("branch_load", pc_b, 32'h100);
    PC_LE = 1'b1; PW = 32'h2000;
    next_edge();
    #2;
    chk("branch_over_inc", pc_b, 32'h2000);
    PC_LE = 1'b0; PW = 32'h100;
    next_edge();
    LE = 1'b0; LE2 = 1'b1; RW2 = 4'd15; PW2 = 32'h3000; PC_LE = 1'b1; RD = 4'd15;
    #2;
    chk("pc_read_no_bypass", pd_b, 32'h108);
    next_edge();
    #2;
    chk("port1_pc_ignored", pc_b, 32'h104);

    // Stall and wrap
    LE2 = 1'b0; LE = 1'b1; RW = 4'd15; PW = 32'h40; PC_LE = 1'b0;
    next_edge();
    LE = 1'b0;
    next_edge();
    #2;
    chk("stall_1", pc_b, 32'h40);
    next_edge();
    #2;
    chk("stall_2", pc_b, 32'h40);
    LE = 1'b1; PW = 32'hFFFFFFFC;
    next_edge();
    LE = 1'b0; PC_LE = 1'b1;
    next_edge();
    PC_LE = 1'b0;
    #2;
    chk("pc_wrap", pc_b, 32'h0);
    chk("pc_wrap_read", pd_b, 32'h8);

    // Reset mid-operation
    LE = 1'b1; RW = 4'd9; PW = 32'h99; LE2 = 1'b1; RW2 = 4'd4; PW2 = 32'h44;
    next_edge();
    LE2 = 1'b0;
    reset = 1'b1; LE = 1'b1; RW = 4'd2; PW = 32'h55; PC_LE = 1'b1;
    RA = 4'd2; RB = 4'd9; RD = 4'd4;
    #2;
    chk("reset_no_bypass", pa_b, 32'h0);
    chk("reset_cycle_stored", pb_b, 32'h99);
    next_edge();
    reset = 1'b0; LE = 1'b0; PC_LE = 1'b0;
    #2;
    chk("post_reset_pc", pc_b, 32'h0);
    chk("post_reset_r2", pa_b, 32'h0);
    chk("post_reset_r9", pb_b, 32'h0);
    chk("post_reset_r4", pd_n, 32'h0);

    // Random traffic, model-checked every cycle
    for (int c = 0; c < 600; c++) begin
      next_edge();
      reset = ($urandom_range(0, 39) == 0);
      LE    = $urandom_range(0, 1) == 1;
      RW    = 4'($urandom_range(0, 15));
      PW    = $urandom();
      LE2   = $urandom_range(0, 1) == 1;
      RW2   = ($urandom_range(0, 3) == 0) ? RW : 4'($urandom_range(0, 15));
      PW2   = $urandom();
      PC_LE = $urandom_range(0, 3) != 0;
      RA    = ($urandom_range(0, 2) == 0) ? RW : 4'($urandom_range(0, 15));
      RB    = ($urandom_range(0, 2) == 0) ? RW2 : 4'($urandom_range(0, 15));
      RD    = 4'($urandom_range(0, 15));
    end
    next_edge();
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
